// File: rtl/sipo_pkg.sv
// Shared types for the serial link: transmitter FSM state and counter sizing.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding register; lets the next word wait while the shifter drains.
module piso_hold_buf
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  full_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  full_q;
  logic [DATA_WIDTH-1:0] data_q;

  // push only happens while empty and pop only while full, so they never collide
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (push_i) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter feeding a sipo_reg receiver, with a
// one-word holding buffer so consecutive words stream without a gap.
module piso_tx
  import sipo_pkg::*;
#(
  parameter int SHIFT_LEFT = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  serial_ready,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  busy,
  output logic                  word_done
);

  localparam int CW = int'(cnt_w(DATA_WIDTH));
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  piso_state_t           state_q;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q;
  logic                  word_done_q, busy_q;

  logic                  hb_full, hb_full_d;
  logic [DATA_WIDTH-1:0] hb_data;
  logic                  load_hs, bit_hs, last, bypass, push, pop, shift_nxt, busy_d;

  piso_hold_buf #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
    .clk    (clk),
    .arst_n (arst_n),
    .push_i (push),
    .pop_i  (pop),
    .data_i (load_data),
    .full_o (hb_full),
    .data_o (hb_data)
  );

  assign load_ready = ~hb_full;

  always_comb begin
    load_hs   = load_valid && !hb_full;
    bit_hs    = (state_q == SHIFT) && serial_ready;
    last      = bit_hs && (cnt_q == CNT_LAST);
    // a word can go straight into the shifter only when it would otherwise sit idle
    bypass    = load_hs && ((state_q == IDLE) || last);
    push      = load_hs && !bypass;
    pop       = last && hb_full;
    hb_full_d = push ? 1'b1 : (pop ? 1'b0 : hb_full);
    if (state_q == IDLE) shift_nxt = load_hs;
    else                 shift_nxt = !(last && !hb_full && !bypass);
    busy_d    = shift_nxt || hb_full_d;
    if (SHIFT_LEFT != 0) shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
    else                 shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      word_done_q <= last;
      busy_q      <= busy_d;
      case (state_q)
        IDLE: begin
          if (load_hs) begin
            shift_q <= load_data;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (last) begin
            cnt_q <= '0;
            if (hb_full)     shift_q <= hb_data;
            else if (bypass) shift_q <= load_data;
            else begin
              shift_q <= shift_d;
              state_q <= IDLE;
            end
          end else if (bit_hs) begin
            cnt_q   <= cnt_q + CW'(1);
            shift_q <= shift_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign serial_out   = (SHIFT_LEFT != 0) ? shift_q[DATA_WIDTH-1] : shift_q[0];
  assign serial_valid = (state_q == SHIFT);
  assign busy         = busy_q;
  assign word_done    = word_done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed checks of piso_tx against a behavioural sipo receiver model.
module tb_piso_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n;
  logic        lv0, sr0, lr0, so0, sv0, bz0, wd0;
  logic [31:0] ld0;
  logic        lv1, sr1, lr1, so1, sv1, bz1, wd1;
  logic [31:0] ld1;
  logic        lv2, sr2, lr2, so2, sv2, bz2, wd2;
  logic [1:0]  ld2;

  logic [31:0] rx0, rx1;
  logic [1:0]  rx2;

  piso_tx #(.SHIFT_LEFT(1), .DATA_WIDTH(32)) u_msb (
    .clk(clk), .arst_n(arst_n), .load_valid(lv0), .load_ready(lr0), .load_data(ld0),
    .serial_ready(sr0), .serial_out(so0), .serial_valid(sv0), .busy(bz0), .word_done(wd0));

  piso_tx #(.SHIFT_LEFT(0), .DATA_WIDTH(32)) u_lsb (
    .clk(clk), .arst_n(arst_n), .load_valid(lv1), .load_ready(lr1), .load_data(ld1),
    .serial_ready(sr1), .serial_out(so1), .serial_valid(sv1), .busy(bz1), .word_done(wd1));

  piso_tx #(.SHIFT_LEFT(1), .DATA_WIDTH(2)) u_w2 (
    .clk(clk), .arst_n(arst_n), .load_valid(lv2), .load_ready(lr2), .load_data(ld2),
    .serial_ready(sr2), .serial_out(so2), .serial_valid(sv2), .busy(bz2), .word_done(wd2));

  // receiver models: we = serial_valid && serial_ready
  always_ff @(posedge clk) if (sv0 && sr0) rx0 <= {rx0[30:0], so0};
  always_ff @(posedge clk) if (sv1 && sr1) rx1 <= {so1, rx1[31:1]};
  always_ff @(posedge clk) if (sv2 && sr2) rx2 <= {rx2[0], so2};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  initial begin
    int          k, cnt, ncap, stalls, unstable, len;
    logic        prev, wdseen, svseen;
    logic [31:0] caps [2];
    logic [63:0] pat;
    logic [7:0]  stream;

    arst_n = 1'b0;
    lv0 = 0; ld0 = '0; sr0 = 1;
    lv1 = 0; ld1 = '0; sr1 = 1;
    lv2 = 0; ld2 = '0; sr2 = 1;
    repeat (2) @(negedge clk);
    chk("rst_so", so0, 0);
    chk("rst_sv", sv0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_wd", wd0, 0);
    chk("rst_lr", lr0, 1);
    arst_n = 1'b1;
    @(negedge clk);

    // MSB first, single word
    lv0 = 1; ld0 = 32'hA5A5_0F0F;
    @(negedge clk);
    lv0 = 0;
    chk("t1_first_sv", sv0, 1);
    chk("t1_first_bit", so0, 1);
    chk("t1_busy", bz0, 1);
    k = 0;
    while (!wd0 && k < 40) begin @(negedge clk); k++; end
    chk("t1_wd_cycles", k, 32);
    chk("t1_rx", rx0, 32'hA5A5_0F0F);
    @(negedge clk);
    chk("t1_wd_once", wd0, 0);
    chk("t1_idle_sv", sv0, 0);
    chk("t1_idle_busy", bz0, 0);

    // LSB first, single set bit
    lv1 = 1; ld1 = 32'h0000_0001;
    @(negedge clk);
    lv1 = 0;
    chk("t2_first_bit", so1, 1);
    @(negedge clk);
    chk("t2_second_bit", so1, 0);
    k = 1;
    while (!wd1 && k < 40) begin @(negedge clk); k++; end
    chk("t2_wd_cycles", k, 32);
    chk("t2_rx", rx1, 32'h0000_0001);

    // back-to-back words through the holding buffer
    lv0 = 1; ld0 = 32'h1234_5678;
    @(negedge clk);
    lv0 = 0;
    cnt = 0; ncap = 0;
    for (int i = 0; i < 100; i++) begin
      if (wd0) begin
        if (ncap < 2) caps[ncap] = rx0;
        ncap++;
      end
      if (sv0) cnt++;
      else break;
      if (i == 5) begin lv0 = 1; ld0 = 32'hDEAD_BEEF; end
      if (i == 6) begin
        lv0 = 0;
        chk("t3_lr_full", lr0, 0);
        chk("t3_busy", bz0, 1);
      end
      @(negedge clk);
    end
    chk("t3_contig", cnt, 64);
    chk("t3_ndone", ncap, 2);
    chk("t3_word0", caps[0], 32'h1234_5678);
    chk("t3_word1", caps[1], 32'hDEAD_BEEF);
    chk("t3_lr_empty", lr0, 1);

    // stalls on serial_ready
    pat = 64'hB6D9_36DB_5A5A_C3C3;
    lv0 = 1; ld0 = 32'hCAFE_F00D;
    @(negedge clk);
    lv0 = 0;
    k = 0; stalls = 0; unstable = 0;
    while (!wd0 && k < 200) begin
      sr0 = pat[k % 64];
      if (!sr0) stalls++;
      prev = so0;
      @(negedge clk);
      k++;
      if (!sr0 && so0 !== prev) unstable++;
    end
    sr0 = 1;
    chk("t4_stalled", (stalls > 0) ? 1 : 0, 1);
    chk("t4_wd_cycles", k, 32 + stalls);
    chk("t4_stable", unstable, 0);
    chk("t4_rx", rx0, 32'hCAFE_F00D);

    // reset mid-word with the buffer full
    lv0 = 1; ld0 = 32'h0F0F_0F0F;
    @(negedge clk);
    ld0 = 32'h1111_2222;
    @(negedge clk);
    lv0 = 0;
    chk("t5_lr_full", lr0, 0);
    repeat (8) @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("t5_rst_sv", sv0, 0);
    chk("t5_rst_so", so0, 0);
    chk("t5_rst_busy", bz0, 0);
    chk("t5_rst_wd", wd0, 0);
    chk("t5_rst_lr", lr0, 1);
    wdseen = 0; svseen = 0;
    repeat (3) begin @(negedge clk); wdseen |= wd0; end
    arst_n = 1'b1;
    repeat (40) begin @(negedge clk); wdseen |= wd0; svseen |= sv0; end
    chk("t5_no_wd", wdseen, 0);
    chk("t5_no_sv", svseen, 0);
    lv0 = 1; ld0 = 32'h3C3C_5A5A;
    @(negedge clk);
    lv0 = 0;
    k = 0;
    while (!wd0 && k < 40) begin @(negedge clk); k++; end
    chk("t5_wd_cycles", k, 32);
    chk("t5_rx", rx0, 32'h3C3C_5A5A);

    // two-bit words, no gap
    lv2 = 1; ld2 = 2'b10;
    @(negedge clk);
    chk("t6_lr", lr2, 1);
    ld2 = 2'b01;
    stream = '0; len = 0;
    for (int i = 0; i < 10; i++) begin
      if (sv2) begin stream = {stream[6:0], so2}; len++; end
      else if (len > 0) break;
      if (i == 1) lv2 = 0;
      @(negedge clk);
    end
    chk("t6_stream", {24'h0, stream}, 32'h0000_0009);
    chk("t6_len", len, 4);
    chk("t6_rx", {30'h0, rx2}, 32'h1);
    chk("t6_wd", wd2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out transmitter: the sending end of the serial link whose receiving end is the `sipo_reg` shift register. It accepts a DATA_WIDTH word through a valid/ready handshake and emits it one bit per accepted cycle on `serial_out`/`serial_valid`. `serial_valid` drives the receiver's `we` directly. Bit order is matched to the receiver's SHIFT_LEFT setting, so that after DATA_WIDTH accepted bits the receiver's `parallel_out` equals the loaded word. A one-entry holding buffer lets consecutive words stream with no idle cycle between them.

## Interface
- SHIFT_LEFT, 1: must equal the receiver's SHIFT_LEFT. 1 = MSB first; 0 = LSB first.
- DATA_WIDTH, 32: word width. Legal range is 2 or more.
- clk  in  1  single clock; all logic on rising edge.
- arst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  `load_data` is valid.
- load_ready  out  1  transmitter can accept a word (equals "holding buffer empty").
- load_data  in  DATA_WIDTH  word to transmit.
- serial_ready  in  1  downstream accepts the current bit this cycle. Tie to 1 if there is no backpressure.
- serial_out  out  1  current bit.
- serial_valid  out  1  `serial_out` is valid; connects to receiver `we`.
- busy  out  1  a word is in the shifter or the holding buffer.
- word_done  out  1  one-cycle pulse, registered, the cycle after the last bit of a word is consumed.

## Operation
- Load handshake: `load_valid && load_ready` at a rising edge.
- Bit handshake: `serial_valid && serial_ready` at a rising edge.
- FSM has two states:
  - IDLE: shifter empty, `serial_valid` = 0.
  - SHIFT: shifter holds a word, `serial_valid` = 1.
- Bit counter: width $clog2(DATA_WIDTH). It counts bits consumed from the current word; terminal value is DATA_WIDTH-1.
- Bit selection:
  - SHIFT_LEFT=1: `serial_out` = shift[DATA_WIDTH-1]; on each consumed bit, shift <= shift << 1.
  - SHIFT_LEFT=0: `serial_out` = shift[0]; on each consumed bit, shift <= shift >> 1.
  - Vacated bits fill with 0.
- Routing of an accepted word:
  - If the state is IDLE, or the last bit is consumed in the same cycle, and the holding buffer is empty: the word loads the shifter directly (bypass).
  - Otherwise the word is written into the holding buffer.
- Last-bit consumed (counter = DATA_WIDTH-1 and bit handshake):
  - Counter clears and `word_done` fires the next cycle.
  - If the holding buffer is full: its word moves into the shifter, the buffer clears, and the state stays SHIFT.
  - Else, if a bypass load happens in the same cycle: stay in SHIFT with the new word.
  - Else: go to IDLE.
- If `serial_ready` = 0, shifter, counter and `serial_out` hold their values.
- `load_data` is sampled only on the handshake. The transmitter never reads it at any other time.
- Reset values (all outputs, asynchronous):
  - `serial_out` 0, `serial_valid` 0, `busy` 0, `word_done` 0, `load_ready` 1.
  - State IDLE, counter 0, holding buffer empty.
- Reset mid-word: the partial word and any buffered word are discarded, with no `word_done`. `serial_valid` drops immediately while `arst_n` is low.

## Timing
- Latency: load handshake at edge N gives the first bit on `serial_out` with `serial_valid`=1 in the cycle after edge N.
- Throughput: with `serial_ready`=1 a word occupies exactly DATA_WIDTH cycles. With the holding buffer refilled in time, back-to-back words produce continuous `serial_valid`.
- `word_done` is high for exactly one cycle after each completed word. With no stalls, consecutive pulses are DATA_WIDTH cycles apart.
- Outputs are registered, except `load_ready`, which is a combinational decode of the buffer flag and has no combinational path from inputs.
- With SHIFT_LEFT matched and `we` = `serial_valid && serial_ready`, the receiver's `parallel_out` equals the word on the edge its last bit is consumed.

## Structure
- Shared package `sipo_pkg`:
  - `piso_state_t` enum {IDLE, SHIFT}.
  - Localparam function for the counter width, $clog2(DATA_WIDTH).
- One natural sub-module: `piso_hold_buf`, a one-entry valid/data register with push/pop. Top level holds the FSM, shifter and counter.

## Test plan
- Reset then load 32'hA5A5_0F0F, SHIFT_LEFT=1, looped back into `sipo_reg` → first bit 1 one cycle after the handshake; after 32 cycles `parallel_out` = 32'hA5A5_0F0F; `word_done` pulses once.
- SHIFT_LEFT=0 on both ends, load 32'h0000_0001 → first bit 1, then 31 zeros; receiver reads 32'h0000_0001.
- Back-to-back 32'h1234_5678 then 32'hDEAD_BEEF, second loaded during the first word → 64 contiguous `serial_valid` cycles; receiver holds each word at its end; `load_ready` low while the buffer is full.
- Random `serial_ready` stalls on 32'hCAFE_F00D → `serial_out` stable during stalls; receiver still reads 32'hCAFE_F00D; `word_done` delayed by the stall count.
- Assert `arst_n` low at bit 10 with the buffer full → all outputs take reset values, no `word_done`; the next load transmits cleanly.
- DATA_WIDTH=2, loads 2'b10 then 2'b01 → serial stream 1,0,0,1 with no gap.
